mul_div_unit: RTL
=================

Name: mul_div_unit

Overview:
- Iterative multiply/divide unit that owns the architectural HI/LO registers.
- Services the MULT/MULTU/DIV/DIVU/MTHI/MTLO requests issued alongside the ALU, and exposes HI/LO for MFHI/MFLO.
- Multi-cycle (radix-2, one bit per clock) with a start/busy/done handshake, so the pipeline stalls on busy.
- Sits in the datapath next to the ALU.

Parameters:
WIDTH, 32, operand width; HI and LO are WIDTH bits each; iteration count = WIDTH

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request strobe; sampled only in IDLE
op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x reserved (no-op)
a  input  WIDTH  rs operand (dividend / multiplicand / MT source)
b  input  WIDTH  rt operand (divisor / multiplier)
busy  output  1  high while an iterative op is in flight
done  output  1  one-cycle pulse when HI/LO receive an iterative result
hi  output  WIDTH  current HI register (MFHI source)
lo  output  WIDTH  current LO register (MFLO source)

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous and active-low.
- Reset: state=IDLE, busy=0, done=0, hi=0, lo=0, counter=0, and all internal operand and accumulator registers cleared.
  - rst_n asserted mid-operation aborts the operation immediately.
  - No partial result reaches hi/lo.
- States: IDLE, MUL, DIV.
- IDLE:
  - start=1 with op MULT/MULTU at edge t0: latch operand magnitudes and result-sign flags, clear counter, go to MUL.
  - start=1 with op DIV/DIVU at edge t0: same latching, go to DIV.
  - start=1 with op MTHI: hi<=a at that edge. With op MTLO: lo<=a at that edge. Stay in IDLE, no done, no busy.
  - Reserved op: ignored.
- busy is registered: 1 from edge t0 through edge t0+WIDTH, i.e. exactly WIDTH cycles.
- MUL: shift-add, one multiplier bit per edge into a 2*WIDTH accumulator.
- DIV: restoring division, one quotient bit per edge.
- Final edge t0+WIDTH:
  - Sign fix-up is applied combinationally and the result is written to hi/lo.
  - busy<=0, done<=1, return to IDLE.
  - done is cleared at the following edge.
- A new start may be accepted on the cycle in which done=1.
- Result placement:
  - MULT/MULTU: {hi,lo} = full 2*WIDTH product. MULT is signed x signed; MULTU is unsigned.
  - DIV/DIVU: lo = quotient, hi = remainder.
  - Signed division truncates toward zero; remainder takes the sign of a.
- Boundaries:
  - DIVU x/0: lo=all ones, hi=x.
  - DIV x/0: lo = (x<0) ? 1 : all ones, hi=x.
  - DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0. No trap.
  - MULT 0x80000000 * 0x80000000: {hi,lo}=0x4000000000000000.
- start while busy: ignored, including MTHI/MTLO; the issuing stage must stall on busy.
- hi/lo outputs hold stable throughout busy and reflect the previous result until the completion edge.
- Operands are latched at t0; a and b may change freely afterwards.

Decomposition:
- Package mdu_pkg: op encodings (OP_MULT..OP_MTLO), state enumeration (IDLE/MUL/DIV), WIDTH-derived counter width constant.
- No sub-module required. Magnitude/negate helpers live in the package as functions, shared by the pre-step and the fix-up.

Test Plan:
- Reset during MUL at cycle 10 → busy=0, done=0, hi=lo=0 immediately; next start behaves normally.
- MULTU a=0xFFFFFFFF b=0xFFFFFFFF → busy for exactly 32 cycles, done pulse 1 cycle, hi=0xFFFFFFFE, lo=0x00000001.
- MULT a=0xFFFFFFFD (-3) b=7 → hi=0xFFFFFFFF, lo=0xFFFFFFEB; then DIV a=-7 b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU 100/0 → lo=0xFFFFFFFF, hi=100. DIV -5/0 → lo=1, hi=0xFFFFFFFB. DIV 0x80000000/-1 → lo=0x80000000, hi=0.
- MTHI a=0x1234 in IDLE → hi=0x1234 next cycle, busy stays 0; MTLO issued while busy → lo unchanged, and the in-flight result still lands at cycle 32.
- Back-to-back: start DIVU 10/3 on the done cycle of a prior MULTU → accepted; after 32 cycles lo=3, hi=1; a and b changed during busy have no effect.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op encodings,
// FSM states, counter sizing and the magnitude/negate helpers.
package mdu_pkg;

    localparam int MDU_WIDTH = 32;
    localparam int CNT_W     = $clog2(MDU_WIDTH);

    typedef logic [MDU_WIDTH-1:0]   word_t;
    typedef logic [2*MDU_WIDTH-1:0] dword_t;

    typedef enum logic [2:0] {
        OP_MULT  = 3'b000,
        OP_MULTU = 3'b001,
        OP_DIV   = 3'b010,
        OP_DIVU  = 3'b011,
        OP_MTHI  = 3'b100,
        OP_MTLO  = 3'b101
    } op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2
    } state_t;

    function automatic word_t neg_word(input word_t v, input logic n);
        return n ? -v : v;
    endfunction

    function automatic dword_t neg_dword(input dword_t v, input logic n);
        return n ? -v : v;
    endfunction

    // Absolute value when the operand is treated as signed, identity otherwise.
    function automatic word_t magnitude(input word_t v, input logic is_signed);
        return neg_word(v, is_signed & v[MDU_WIDTH-1]);
    endfunction

endpackage

// File: rtl/mul_div_unit.sv
// Radix-2 multiply/divide unit owning HI/LO. Works on operand magnitudes and
// applies the sign fix-up on the final iteration. WIDTH must match MDU_WIDTH.
module mul_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t state, state_d;

    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   opb;
    logic               neg_q;
    logic               neg_r;

    logic               is_signed;
    logic               take_mul;
    logic               take_div;
    logic               take_mthi;
    logic               take_mtlo;
    logic               last;

    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic [2*WIDTH-1:0] acc_nxt;
    logic [2*WIDTH-1:0] product;
    logic [WIDTH-1:0]   res_hi;
    logic [WIDTH-1:0]   res_lo;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d   = state;
        take_mul  = 1'b0;
        take_div  = 1'b0;
        take_mthi = 1'b0;
        take_mtlo = 1'b0;
        last      = 1'b0;
        is_signed = (op == OP_MULT) || (op == OP_DIV);
        case (state)
            IDLE: begin
                if (start) begin
                    case (op)
                        OP_MULT, OP_MULTU: begin
                            take_mul = 1'b1;
                            state_d  = MUL;
                        end
                        OP_DIV, OP_DIVU: begin
                            take_div = 1'b1;
                            state_d  = DIV;
                        end
                        OP_MTHI: take_mthi = 1'b1;
                        OP_MTLO: take_mtlo = 1'b1;
                        default: ;
                    endcase
                end
            end
            MUL, DIV: begin
                if (cnt == LAST) begin
                    last    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Division keeps {remainder, dividend/quotient} in acc and shifts one bit per step.
    always_comb begin
        div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opb};
        if (state == MUL) begin
            acc_nxt = acc + (opb[0] ? mcand : '0);
        end else if (div_diff[WIDTH]) begin
            acc_nxt = {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        end else begin
            acc_nxt = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        end
        product = neg_dword(acc_nxt, neg_q);
        if (state == MUL) begin
            res_hi = product[2*WIDTH-1:WIDTH];
            res_lo = product[WIDTH-1:0];
        end else begin
            res_hi = neg_word(acc_nxt[2*WIDTH-1:WIDTH], neg_r);
            res_lo = neg_word(acc_nxt[WIDTH-1:0], neg_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            acc   <= '0;
            mcand <= '0;
            opb   <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            done <= 1'b0;
            if (take_mul || take_div) begin
                cnt   <= '0;
                busy  <= 1'b1;
                neg_q <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                neg_r <= is_signed & a[WIDTH-1];
                opb   <= magnitude(b, is_signed);
                if (take_mul) begin
                    acc   <= '0;
                    mcand <= {WIDTH'(0), magnitude(a, is_signed)};
                end else begin
                    acc   <= {WIDTH'(0), magnitude(a, is_signed)};
                    mcand <= '0;
                end
            end
            if (take_mthi) begin
                hi <= a;
            end
            if (take_mtlo) begin
                lo <= a;
            end
            if (state == MUL || state == DIV) begin
                acc <= acc_nxt;
                cnt <= cnt + CNT_W'(1);
                if (state == MUL) begin
                    mcand <= mcand << 1;
                    opb   <= opb >> 1;
                end
            end
            // HI/LO only change here, so nothing partial is ever visible.
            if (last) begin
                hi   <= res_hi;
                lo   <= res_lo;
                busy <= 1'b0;
                done <= 1'b1;
            end
        end
    end

endmodule
